// File: rtl/serial_logic_rx_8bit.sv
// rtl/serial_logic_rx_8bit.sv - bit-serial logic-op receiver, LSB-first, assembles WIDTH-bit result words
// Applies AND/OR/XOR/NAND to each valid bit pair and strobes the assembled word on frame completion.
module serial_logic_rx_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic [1:0]       op,
  input  logic             abort,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic [1:0]       eff_op;
  logic             r;

  // The first bit of a frame uses the live op; later bits use the latched copy.
  always_comb begin
    eff_op = (state_q == IDLE) ? op : op_q;
    unique case (eff_op)
      2'b00:   r = a_bit & b_bit;
      2'b01:   r = a_bit | b_bit;
      2'b10:   r = a_bit ^ b_bit;
      default: r = ~(a_bit & b_bit);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sh_d      = sh_q;
    o_d       = o_q;
    o_valid_d = 1'b0;

    if (abort) begin
      // Partial frame is dropped; sh is left as-is since it is rebuilt by the next frame.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          op_d    = op;
          sh_d    = {r, sh_q[WIDTH-1:1]};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            o_d       = {r, sh_q[WIDTH-1:1]};
            o_valid_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            sh_d  = {r, sh_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      sh_q      <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sh_q      <= sh_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_logic_rx_8bit.sv
// tb/tb_serial_logic_rx_8bit.sv - directed scoreboard bench for serial_logic_rx_8bit
module tb_serial_logic_rx_8bit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a_bit;
  logic       b_bit;
  logic [1:0] op;
  logic       abort;
  logic [7:0] o;
  logic       o_valid;
  logic       busy;

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] sb[$];
  logic [7:0] o_prev;
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  serial_logic_rx_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_bit(a_bit), .b_bit(b_bit),
    .op(op), .abort(abort), .o(o), .o_valid(o_valid), .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic a, input logic b, input logic [1:0] opv, input logic ab);
    in_valid = v; a_bit = a; b_bit = b; op = opv; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_check(input string tag, input bit done, input bit exp_busy);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    if (done) begin
      chk({tag, " o_valid"}, {31'd0, o_valid}, 32'd1);
      chk({tag, " sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        chk({tag, " o"}, {24'd0, o}, {24'd0, exp_w});
      end
      o_prev = o;
    end else begin
      chk({tag, " no_o_valid"}, {31'd0, o_valid}, 32'd0);
      chk({tag, " o_hold"}, {24'd0, o}, {24'd0, o_prev});
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] op0, input logic [1:0] op_rest,
                            input int gap, input logic [7:0] exp);
    sb.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, a[i], b[i], (i == 0) ? op0 : op_rest, 1'b0);
      cyc_check(tag, i == 7, i != 7);
      if (i != 7) begin
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)), 1'b0);
          cyc_check({tag, " gap"}, 1'b0, 1'b1);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0; op = 2'b00; abort = 1'b0;
    o_prev = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("reset o", {24'd0, o}, 32'h0);
    chk("reset o_valid", {31'd0, o_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc_check("idle", 1'b0, 1'b0);

    send_frame("and",  8'hF0, 8'h3C, 2'b00, 2'b00, 0, 8'h30);
    send_frame("or",   8'hF0, 8'h3C, 2'b01, 2'b01, 0, 8'hFC);
    send_frame("xor",  8'hF0, 8'h3C, 2'b10, 2'b10, 0, 8'hCC);
    send_frame("nand", 8'hF0, 8'h3C, 2'b11, 2'b11, 0, 8'hCF);
    send_frame("xor_opchg", 8'hF0, 8'h3C, 2'b10, 2'b00, 0, 8'hCC);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc_check("pulse_end", 1'b0, 1'b0);

    send_frame("gap_and", 8'hA5, 8'hFF, 2'b00, 2'b00, 3, 8'hA5);

    send_frame("b2b_1", 8'hFF, 8'h0F, 2'b00, 2'b00, 0, 8'h0F);
    send_frame("b2b_2", 8'h81, 8'hFF, 2'b00, 2'b00, 0, 8'h81);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, i[0], 2'b01, 1'b0);
      cyc_check("abort_pre", 1'b0, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
    cyc_check("abort", 1'b0, 1'b0);
    send_frame("post_abort_or", 8'h00, 8'h5A, 2'b01, 2'b01, 0, 8'h5A);

    send_frame("pre_rst_and", 8'hF0, 8'h3C, 2'b00, 2'b00, 0, 8'h30);
    chk("pre_rst o", {24'd0, o}, 32'h30);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
      cyc_check("rst_pre", 1'b0, 1'b1);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    rst = 1'b0;
    chk("mid_rst o", {24'd0, o}, 32'h0);
    chk("mid_rst busy", {31'd0, busy}, 32'd0);
    chk("mid_rst o_valid", {31'd0, o_valid}, 32'd0);
    o_prev = 8'h00;
    send_frame("post_rst_and", 8'hF0, 8'h3C, 2'b00, 2'b00, 0, 8'h30);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc_check("final", 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
